// File: rtl/operand_sel_pipe_if.sv
// Handshake bundle for operand_sel_pipe: operand offer with select code, flush, held-result output.
// master = producer/consumer side, slave = the pipe stage.
interface operand_sel_pipe_if #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 3
);
   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [2:0]              in_sel;
   logic                    in_valid;
   logic                    in_ready;
   logic                    flush;
   logic [WIDTH-1:0]        out_data;
   logic                    out_valid;
   logic                    out_ready;

   modport master (
      output in_data, in_sel, in_valid, flush, out_ready,
      input  in_ready, out_data, out_valid
   );

   modport slave (
      input  in_data, in_sel, in_valid, flush, out_ready,
      output in_ready, out_data, out_valid
   );
endinterface

// File: rtl/operand_sel_pipe.sv
// Single-entry operand select stage; optional out-of-range counter via OPERAND_SEL_ERR_EN.
// Latency 1 cycle from accept to out_valid; full throughput with simultaneous consume+accept.
// Backpressure: in_ready = !out_valid || out_ready; held result frozen while out_ready=0.
module operand_sel_pipe #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 3
) (
   input  logic              clk,
   input  logic              reset,
   operand_sel_pipe_if.slave bus
`ifdef OPERAND_SEL_ERR_EN
   ,
   output logic [7:0]        sel_err_cnt
`endif
);

   logic             accept;
   logic [WIDTH-1:0] sel_data;

   // Codes with no matching input fall through to the zero default.
   always_comb begin
      sel_data = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         if (bus.in_sel == 3'(k)) begin
            sel_data = bus.in_data[k*WIDTH +: WIDTH];
         end
      end
   end

   assign bus.in_ready = !bus.out_valid || bus.out_ready;

   // flush kills the accept but leaves in_ready untouched.
   assign accept = bus.in_valid && bus.in_ready && !bus.flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
      end else if (bus.flush) begin
         bus.out_valid <= 1'b0;
      end else if (accept) begin
         bus.out_valid <= 1'b1;
         bus.out_data  <= sel_data;
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

`ifdef OPERAND_SEL_ERR_EN
   localparam logic [3:0] NUM_IN_C = 4'(NUM_IN);

   logic sel_oor;

   assign sel_oor = ({1'b0, bus.in_sel} >= NUM_IN_C);

   always_ff @(posedge clk) begin
      if (reset) begin
         sel_err_cnt <= 8'd0;
      end else if (accept && sel_oor && (sel_err_cnt != 8'hFF)) begin
         sel_err_cnt <= sel_err_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_operand_sel_pipe.sv
// Directed scoreboard bench: a 32-bit/3-input stage and an 8-bit/8-input stage.
module tb_operand_sel_pipe;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   operand_sel_pipe_if #(.WIDTH(32), .NUM_IN(3)) bus_a ();
   operand_sel_pipe_if #(.WIDTH(8),  .NUM_IN(8)) bus_b ();

`ifdef OPERAND_SEL_ERR_EN
   logic [7:0] cnt_a;
   logic [7:0] cnt_b;
`endif

   operand_sel_pipe #(.WIDTH(32), .NUM_IN(3)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
`ifdef OPERAND_SEL_ERR_EN
      ,
      .sel_err_cnt (cnt_a)
`endif
   );

   operand_sel_pipe #(.WIDTH(8), .NUM_IN(8)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
`ifdef OPERAND_SEL_ERR_EN
      ,
      .sel_err_cnt (cnt_b)
`endif
   );

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] q_a[$];
   logic [7:0]  q_b[$];

   localparam logic [95:0] DATA_A = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
   localparam logic [63:0] DATA_B = 64'h8877_6655_4433_2211;

   logic [31:0] exp_a[4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h0000_0000};
   logic [7:0]  exp_b[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Completed transfers are checked against the queued expectations.
   always @(negedge clk) begin
      logic [31:0] ea;
      logic [7:0]  eb;
      if (reset !== 1'b1 && bus_a.out_valid === 1'b1 && bus_a.out_ready === 1'b1 && bus_a.flush !== 1'b1) begin
         if (q_a.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL mon_a unexpected transfer: got %0h expected none", bus_a.out_data);
         end else begin
            ea = q_a.pop_front();
            chk("mon_a data", 64'(bus_a.out_data), 64'(ea));
         end
      end
      if (reset !== 1'b1 && bus_b.out_valid === 1'b1 && bus_b.out_ready === 1'b1 && bus_b.flush !== 1'b1) begin
         if (q_b.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL mon_b unexpected transfer: got %0h expected none", bus_b.out_data);
         end else begin
            eb = q_b.pop_front();
            chk("mon_b data", 64'(bus_b.out_data), 64'(eb));
         end
      end
   end

   initial begin
      reset           = 1'b1;
      bus_a.in_data   = DATA_A;
      bus_a.in_sel    = 3'd1;
      bus_a.in_valid  = 1'b1;
      bus_a.flush     = 1'b1;
      bus_a.out_ready = 1'b0;
      bus_b.in_data   = DATA_B;
      bus_b.in_sel    = 3'd0;
      bus_b.in_valid  = 1'b0;
      bus_b.flush     = 1'b0;
      bus_b.out_ready = 1'b0;

      // Reset with an offer and a flush pending: both ignored.
      step();
      chk("rst out_valid", 64'(bus_a.out_valid), 64'd0);
      chk("rst out_data", 64'(bus_a.out_data), 64'd0);
      chk("rst in_ready", 64'(bus_a.in_ready), 64'd1);
`ifdef OPERAND_SEL_ERR_EN
      chk("rst cnt", 64'(cnt_a), 64'd0);
`endif
      step();
      reset          = 1'b0;
      bus_a.in_valid = 1'b0;
      bus_a.flush    = 1'b0;
      #1;
      chk("post-rst in_ready", 64'(bus_a.in_ready), 64'd1);
      chk("post-rst out_valid", 64'(bus_a.out_valid), 64'd0);

      // Back-to-back selects including out-of-range code 3.
      bus_a.out_ready = 1'b1;
      for (int s = 0; s < 4; s++) begin
         bus_a.in_valid = 1'b1;
         bus_a.in_sel   = 3'(s);
         q_a.push_back(exp_a[s]);
         step();
         chk("b2b out_valid", 64'(bus_a.out_valid), 64'd1);
      end
      bus_a.in_valid = 1'b0;
      step();
      chk("drain out_valid", 64'(bus_a.out_valid), 64'd0);

      // Hold under backpressure while inputs churn.
      bus_a.out_ready = 1'b0;
      bus_a.in_valid  = 1'b1;
      bus_a.in_sel    = 3'd1;
      q_a.push_back(32'h2222_2222);
      step();
      chk("hold out_valid", 64'(bus_a.out_valid), 64'd1);
      for (int i = 0; i < 3; i++) begin
         bus_a.in_data = {3{32'hA5A5_0000 + 32'(i)}};
         bus_a.in_sel  = 3'(i);
         #1;
         chk("hold in_ready", 64'(bus_a.in_ready), 64'd0);
         step();
         chk("hold out_data", 64'(bus_a.out_data), 64'h2222_2222);
         chk("hold valid", 64'(bus_a.out_valid), 64'd1);
      end
      bus_a.in_data   = DATA_A;
      bus_a.in_valid  = 1'b0;
      bus_a.out_ready = 1'b1;
      step();
      chk("release out_valid", 64'(bus_a.out_valid), 64'd0);

      // Flush of a held result with a competing offer.
      bus_a.in_valid  = 1'b1;
      bus_a.in_sel    = 3'd0;
      bus_a.out_ready = 1'b0;
      step();
      chk("pre-flush valid", 64'(bus_a.out_valid), 64'd1);
      bus_a.flush  = 1'b1;
      bus_a.in_sel = 3'd2;
      step();
      chk("flush out_valid", 64'(bus_a.out_valid), 64'd0);
      bus_a.flush     = 1'b0;
      bus_a.out_ready = 1'b1;
      q_a.push_back(32'h3333_3333);
      step();
      chk("post-flush accept", 64'(bus_a.out_valid), 64'd1);
      bus_a.in_valid = 1'b0;
      step();
      chk("post-flush drain", 64'(bus_a.out_valid), 64'd0);

      // Flush while empty and ready: in_ready stays 1, accept blocked.
      bus_a.flush    = 1'b1;
      bus_a.in_valid = 1'b1;
      bus_a.in_sel   = 3'd0;
      #1;
      chk("flush in_ready", 64'(bus_a.in_ready), 64'd1);
      step();
      chk("flush blocks accept", 64'(bus_a.out_valid), 64'd0);
      bus_a.flush    = 1'b0;
      bus_a.in_valid = 1'b0;

      // Reset discards a held result.
      bus_a.in_data   = {DATA_A[95:32], 32'hDEAD_BEEF};
      bus_a.in_sel    = 3'd0;
      bus_a.in_valid  = 1'b1;
      bus_a.out_ready = 1'b0;
      step();
      chk("beef held", 64'(bus_a.out_data), 64'hDEAD_BEEF);
      reset        = 1'b1;
      bus_a.in_sel = 3'd1;
      step();
      chk("mid-hold rst valid", 64'(bus_a.out_valid), 64'd0);
      chk("mid-hold rst data", 64'(bus_a.out_data), 64'd0);
      chk("mid-hold rst in_ready", 64'(bus_a.in_ready), 64'd1);
      reset          = 1'b0;
      bus_a.in_valid = 1'b0;
      bus_a.in_data  = DATA_A;

`ifdef OPERAND_SEL_ERR_EN
      chk("cnt after rst", 64'(cnt_a), 64'd0);
      bus_a.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus_a.in_valid = 1'b1;
         bus_a.in_sel   = 3'd7;
         q_a.push_back(32'h0);
         step();
      end
      bus_a.in_valid = 1'b0;
      step();
      chk("cnt 10", 64'(cnt_a), 64'd10);
      bus_a.flush    = 1'b1;
      bus_a.in_valid = 1'b1;
      bus_a.in_sel   = 3'd7;
      step();
      step();
      bus_a.flush = 1'b0;
      chk("cnt flush", 64'(cnt_a), 64'd10);
      bus_a.in_sel = 3'd2;
      q_a.push_back(32'h3333_3333);
      step();
      bus_a.in_valid = 1'b0;
      step();
      chk("cnt in-range", 64'(cnt_a), 64'd10);
      bus_a.out_ready = 1'b0;
      bus_a.in_valid  = 1'b1;
      bus_a.in_sel    = 3'd2;
      q_a.push_back(32'h3333_3333);
      step();
      bus_a.in_sel = 3'd7;
      step();
      chk("cnt unaccepted", 64'(cnt_a), 64'd10);
      bus_a.in_valid  = 1'b0;
      bus_a.out_ready = 1'b1;
      step();
      for (int i = 0; i < 290; i++) begin
         bus_a.in_valid = 1'b1;
         bus_a.in_sel   = 3'd7;
         q_a.push_back(32'h0);
         step();
         if (i == 239) chk("cnt 250", 64'(cnt_a), 64'd250);
      end
      bus_a.in_valid = 1'b0;
      step();
      chk("cnt saturate", 64'(cnt_a), 64'd255);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("cnt rst", 64'(cnt_a), 64'd0);
`endif

      // Eight live inputs: every code is in range.
      bus_b.out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         bus_b.in_valid = 1'b1;
         bus_b.in_sel   = 3'(k);
         q_b.push_back(exp_b[k]);
         step();
         chk("b8 out_valid", 64'(bus_b.out_valid), 64'd1);
      end
      bus_b.in_valid = 1'b0;
      step();
      chk("b8 drain", 64'(bus_b.out_valid), 64'd0);
`ifdef OPERAND_SEL_ERR_EN
      chk("b8 cnt", 64'(cnt_b), 64'd0);
`endif

      step();
      step();
      chk("q_a empty", 64'(q_a.size()), 64'd0);
      chk("q_b empty", 64'(q_b.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
